amba_write_slave: RTL and testbench

- Slave-side write endpoint; sits directly downstream of amba__write_channel and consumes its slave-facing AW/W signals and returns B.
- Latches one write address burst and buffers incoming W beats in an internal FIFO.
- Drains the FIFO into a byte-wide memory write port and returns a single B response per burst.
- One burst outstanding at a time.

---
 rtl/amba_pkg.sv | 19 +
 rtl/amba_sync_fifo.sv | 47 ++++
 rtl/amba_write_slave.sv | 181 ++++++++++++++++++
 tb/tb_amba_write_slave.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amba_pkg.sv
// Shared encodings for the AXI-style write slave: burst types, response codes
// and the slave FSM state type.
package amba_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        DRAIN,
        RESP
    } state_t;

endpackage

// File: rtl/amba_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data; full/empty come
// from read/write pointers carrying one extra wrap bit.
module amba_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/amba_write_slave.sv
// Write-slave endpoint: accepts one AW burst, buffers W beats in a FIFO,
// drains them to a byte-wide memory port and returns a single B response.
module amba_write_slave
    import amba_pkg::*;
#(
    parameter int ID_W       = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ID_W-1:0]   i2s_AWID,
    input  logic [ADDR_W-1:0] i2s_AWADDR,
    input  logic [3:0]        i2s_AWLEN,
    input  logic [2:0]        i2s_AWSIZE,
    input  logic [1:0]        i2s_AWBURST,
    input  logic              i2s_AWVALID,
    output logic              s2i_AWREADY,
    input  logic [ID_W-1:0]   i2s_WID,
    input  logic [DATA_W-1:0] i2s_WDATA,
    input  logic              i2s_WSTRB,
    input  logic              i2s_WLAST,
    input  logic              i2s_WVALID,
    output logic              s2i_WREADY,
    output logic [ID_W-1:0]   s2i_BID,
    output logic [1:0]        s2i_BRESP,
    output logic              s2i_BVALID,
    input  logic              i2s_BREADY,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);

    localparam int FW = DATA_W + 2;

    state_t            state;
    logic [ID_W-1:0]   id_q;
    logic [3:0]        len_q;
    logic [1:0]        burst_q;
    logic [ADDR_W-1:0] cur_addr;
    logic [3:0]        beat_cnt;
    logic              aw_err;
    logic              err;
    logic              last_popped;

    logic              aw_hs;
    logic              w_hs;
    logic              id_ok;
    logic              strb_eff;
    logic              last_eff;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FW-1:0]     din;
    logic [FW-1:0]     dout;

    function automatic logic aw_invalid(input logic [2:0] size, input logic [1:0] burst,
                                        input logic [3:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        return (size != 3'd0) || (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    // WRAP keeps the upper bits and lets the low bits roll over inside the
    // (len+1)-byte window; len+1 is a power of two whenever writes are enabled.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [1:0] burst,
                                                    input logic [3:0] len);
        logic [ADDR_W-1:0] mask;
        logic [ADDR_W-1:0] inc;
        mask = ADDR_W'(len);
        inc  = a + ADDR_W'(1);
        case (burst)
            BURST_FIXED: return a;
            BURST_WRAP:  return (a & ~mask) | (inc & mask);
            default:     return inc;
        endcase
    endfunction

    assign aw_hs      = i2s_AWVALID && s2i_AWREADY;
    assign s2i_WREADY = (state == DATA) && !fifo_full;
    assign w_hs       = i2s_WVALID && s2i_WREADY;
    assign id_ok      = (i2s_WID == id_q);
    assign strb_eff   = id_ok && i2s_WSTRB;
    assign last_eff   = i2s_WLAST || (beat_cnt == len_q);
    assign din        = {i2s_WDATA, strb_eff, last_eff};
    assign push       = w_hs;
    assign pop        = ((state == DATA) || (state == DRAIN)) && !fifo_empty;

    amba_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            id_q     <= i2s_AWID;
            len_q    <= i2s_AWLEN;
            burst_q  <= i2s_AWBURST;
            cur_addr <= i2s_AWADDR;
        end else if (pop) begin
            cur_addr <= next_addr(cur_addr, burst_q, len_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            s2i_AWREADY <= 1'b0;
            s2i_BVALID  <= 1'b0;
            s2i_BID     <= '0;
            s2i_BRESP   <= RESP_OKAY;
            aw_err      <= 1'b0;
            err         <= 1'b0;
            beat_cnt    <= '0;
            last_popped <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            // Drain stage: one FIFO entry becomes one registered memory cycle.
            mem_we <= pop && dout[1] && !aw_err;
            if (pop) begin
                mem_addr  <= cur_addr;
                mem_wdata <= dout[FW-1:2];
            end
            if (pop && dout[0]) last_popped <= 1'b1;

            case (state)
                IDLE: begin
                    s2i_AWREADY <= 1'b1;
                    if (aw_hs) begin
                        s2i_AWREADY <= 1'b0;
                        aw_err      <= aw_invalid(i2s_AWSIZE, i2s_AWBURST, i2s_AWLEN);
                        err         <= aw_invalid(i2s_AWSIZE, i2s_AWBURST, i2s_AWLEN);
                        beat_cnt    <= '0;
                        last_popped <= 1'b0;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        // Early WLAST, missing WLAST and foreign WID all poison the burst.
                        if (!id_ok || (i2s_WLAST != (beat_cnt == len_q))) err <= 1'b1;
                        if (last_eff) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Wait one extra cycle so BVALID follows the final memory write.
                    if (last_popped) begin
                        s2i_BVALID <= 1'b1;
                        s2i_BID    <= id_q;
                        s2i_BRESP  <= err ? RESP_SLVERR : RESP_OKAY;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (i2s_BREADY) begin
                        s2i_BVALID  <= 1'b0;
                        s2i_AWREADY <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amba_write_slave.sv
// Randomized scoreboard bench for amba_write_slave: a burst-level model predicts
// every memory write and B response; a monitor checks them as they appear.
module tb_amba_write_slave;

    localparam int ID_W       = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ID_W-1:0]   i2s_AWID = '0;
    logic [ADDR_W-1:0] i2s_AWADDR = '0;
    logic [3:0]        i2s_AWLEN = '0;
    logic [2:0]        i2s_AWSIZE = '0;
    logic [1:0]        i2s_AWBURST = '0;
    logic              i2s_AWVALID = 1'b0;
    logic              s2i_AWREADY;
    logic [ID_W-1:0]   i2s_WID = '0;
    logic [DATA_W-1:0] i2s_WDATA = '0;
    logic              i2s_WSTRB = 1'b0;
    logic              i2s_WLAST = 1'b0;
    logic              i2s_WVALID = 1'b0;
    logic              s2i_WREADY;
    logic [ID_W-1:0]   s2i_BID;
    logic [1:0]        s2i_BRESP;
    logic              s2i_BVALID;
    logic              i2s_BREADY = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    amba_write_slave #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .i2s_AWID(i2s_AWID), .i2s_AWADDR(i2s_AWADDR), .i2s_AWLEN(i2s_AWLEN),
        .i2s_AWSIZE(i2s_AWSIZE), .i2s_AWBURST(i2s_AWBURST), .i2s_AWVALID(i2s_AWVALID),
        .s2i_AWREADY(s2i_AWREADY),
        .i2s_WID(i2s_WID), .i2s_WDATA(i2s_WDATA), .i2s_WSTRB(i2s_WSTRB),
        .i2s_WLAST(i2s_WLAST), .i2s_WVALID(i2s_WVALID), .s2i_WREADY(s2i_WREADY),
        .s2i_BID(s2i_BID), .s2i_BRESP(s2i_BRESP), .s2i_BVALID(s2i_BVALID),
        .i2s_BREADY(i2s_BREADY),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; int cyc; } wr_t;
    typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; int cyc; } b_t;
    wr_t exp_wr[$];
    b_t  exp_b[$];

    int n_vec = 0;
    int n_err = 0;

    logic [ID_W-1:0]   bw_id   [16];
    logic [DATA_W-1:0] bw_data [16];
    logic              bw_strb [16];
    logic              bw_last [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected address of beat i, straight from the burst definitions.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [1:0] burst,
                                                    input int len, input int i);
        longint unsigned n, base;
        n = len + 1;
        case (burst)
            2'b00: return a;
            2'b10: begin
                base = a - (a % n);
                return ADDR_W'(base + ((a - base + i) % n));
            end
            default: return ADDR_W'(longint'(a) + i);
        endcase
    endfunction

    task automatic fill_beats(input logic [ID_W-1:0] id, input int len, input logic [7:0] d0);
        for (int i = 0; i < 16; i++) begin
            bw_id[i]   = id;
            bw_data[i] = d0 + 8'(i);
            bw_strb[i] = 1'b1;
            bw_last[i] = (i == len);
        end
    endtask

    // Drives one burst, records expectations as beats are accepted, then
    // completes the B handshake after holding BREADY low for 'hold' cycles.
    task automatic run_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                             input int len, input logic [2:0] size, input logic [1:0] burst,
                             input int gap_max, input int hold, input int stop_after);
        int n, w, last_cyc;
        bit aw_err, err;
        n = 0;
        for (int i = 0; i <= len; i++) begin
            n++;
            if (bw_last[i] || i == len) break;
        end
        aw_err = (size != 0) || (burst == 2'b11) ||
                 (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
        err = aw_err;
        for (int i = 0; i < n; i++) begin
            if (bw_id[i] != id) err = 1;
            if (bw_last[i] && i < len) err = 1;
            if (i == len && !bw_last[i]) err = 1;
        end

        @(posedge clk); #1;
        i2s_AWID = id; i2s_AWADDR = addr; i2s_AWLEN = 4'(len);
        i2s_AWSIZE = size; i2s_AWBURST = burst; i2s_AWVALID = 1'b1;
        w = 0;
        @(negedge clk);
        while (!s2i_AWREADY) begin
            w++;
            if (w > 50) begin
                check("aw_timeout", 0, 1);
                i2s_AWVALID = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        i2s_AWVALID = 1'b0;

        last_cyc = 0;
        for (int i = 0; i < n; i++) begin
            if (stop_after > 0 && i == stop_after) return;
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            i2s_WID = bw_id[i]; i2s_WDATA = bw_data[i]; i2s_WSTRB = bw_strb[i];
            i2s_WLAST = bw_last[i]; i2s_WVALID = 1'b1;
            w = 0;
            @(negedge clk);
            while (!s2i_WREADY) begin
                w++;
                if (w > 50) begin
                    check("w_timeout", 0, 1);
                    i2s_WVALID = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            if (!aw_err && bw_id[i] == id && bw_strb[i])
                exp_wr.push_back('{addr: beat_addr(addr, burst, len, i), data: bw_data[i], cyc: cyc + 2});
            last_cyc = cyc;
            @(posedge clk); #1;
            i2s_WVALID = 1'b0;
            i2s_WLAST  = 1'b0;
        end
        exp_b.push_back('{id: id, resp: err ? 2'b10 : 2'b00, cyc: last_cyc + 3});

        w = 0;
        while (!s2i_BVALID) begin
            @(negedge clk);
            w++;
            if (w > 100) begin
                check("b_timeout", 0, 1);
                return;
            end
        end
        repeat (hold) begin
            @(negedge clk);
            check("bvalid_hold", s2i_BVALID, 1);
            check("awready_hold", s2i_AWREADY, 0);
        end
        @(posedge clk); #1;
        i2s_BREADY = 1'b1;
        @(posedge clk); #1;
        i2s_BREADY = 1'b0;
    endtask

    logic bv_prev = 1'b0;
    always @(negedge clk) begin
        wr_t e;
        b_t  b;
        if (reset) begin
            if (mem_we) begin
                if (exp_wr.size() == 0) check("unexpected_write", 1, 0);
                else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", mem_addr, e.addr);
                    check("wr_data", mem_wdata, e.data);
                    check("wr_cycle", cyc, e.cyc);
                end
            end
            if (s2i_BVALID && !bv_prev) begin
                if (exp_b.size() == 0) check("unexpected_bvalid", 1, 0);
                else check("b_latency", cyc, exp_b[0].cyc);
            end
            if (s2i_BVALID && i2s_BREADY && exp_b.size() > 0) begin
                b = exp_b.pop_front();
                check("bid", s2i_BID, b.id);
                check("bresp", s2i_BRESP, b.resp);
            end
        end
        bv_prev = s2i_BVALID;
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_awready"}, s2i_AWREADY, 0);
        check({tag, "_wready"}, s2i_WREADY, 0);
        check({tag, "_bvalid"}, s2i_BVALID, 0);
        check({tag, "_bid"}, s2i_BID, 0);
        check({tag, "_bresp"}, s2i_BRESP, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        #150000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ID_W-1:0]   rid;
        logic [ADDR_W-1:0] raddr;
        int                rlen;
        logic [1:0]        rburst;
        logic [2:0]        rsize;

        #1 reset = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        #1 check("awready_after_release", s2i_AWREADY, 0);
        @(negedge clk);
        check("awready_idle", s2i_AWREADY, 1);

        fill_beats(4'd6, 7, 8'h10);
        run_burst(4'd6, 32'h309, 7, 3'd0, 2'b01, 1, 0, 0);

        fill_beats(4'd3, 3, 8'h50);
        run_burst(4'd3, 32'h40, 3, 3'd0, 2'b00, 1, 0, 0);

        fill_beats(4'd1, 3, 8'h60);
        run_burst(4'd1, 32'h106, 3, 3'd0, 2'b10, 1, 0, 0);

        fill_beats(4'd1, 2, 8'h70);
        run_burst(4'd1, 32'h106, 2, 3'd0, 2'b10, 1, 0, 0);

        fill_beats(4'd9, 15, 8'h80);
        run_burst(4'd9, 32'h1000, 15, 3'd0, 2'b01, 0, 5, 0);

        fill_beats(4'd6, 7, 8'h20);
        bw_id[2] = 4'd10;
        run_burst(4'd6, 32'h200, 7, 3'd0, 2'b01, 1, 0, 0);

        fill_beats(4'd6, 7, 8'h30);
        bw_last[1] = 1'b1;
        run_burst(4'd6, 32'h300, 7, 3'd0, 2'b01, 1, 0, 0);

        fill_beats(4'd4, 5, 8'h40);
        bw_strb[3] = 1'b0;
        run_burst(4'd4, 32'h400, 5, 3'd0, 2'b01, 1, 0, 0);

        fill_beats(4'd5, 3, 8'h90);
        bw_last[3] = 1'b0;
        run_burst(4'd5, 32'hFFFF_FFFE, 3, 3'd0, 2'b01, 1, 0, 0);

        fill_beats(4'd7, 1, 8'hA0);
        run_burst(4'd7, 32'h500, 1, 3'd1, 2'b01, 1, 0, 0);
        fill_beats(4'd7, 1, 8'hB0);
        run_burst(4'd7, 32'h500, 1, 3'd0, 2'b11, 1, 0, 0);

        // Reset in the middle of a burst: pending work is discarded.
        fill_beats(4'd2, 7, 8'hC0);
        run_burst(4'd2, 32'h600, 7, 3'd0, 2'b01, 0, 0, 3);
        @(negedge clk); #1;
        reset = 1'b0;
        #1 check_outputs_zero("midreset");
        exp_wr.delete();
        exp_b.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        fill_beats(4'd2, 7, 8'hD0);
        run_burst(4'd2, 32'h700, 7, 3'd0, 2'b01, 1, 0, 0);

        for (int k = 0; k < 40; k++) begin
            rid    = ID_W'($urandom);
            raddr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
            rlen   = $urandom_range(0, 15);
            rburst = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            rsize  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            for (int i = 0; i < 16; i++) begin
                bw_id[i]   = ($urandom_range(0, 9) == 0) ? (rid ^ 4'h5) : rid;
                bw_data[i] = DATA_W'($urandom);
                bw_strb[i] = ($urandom_range(0, 7) != 0);
                bw_last[i] = (i == rlen) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 29) == 0);
            end
            run_burst(rid, raddr, rlen, rsize, rburst, 2, $urandom_range(0, 3), 0);
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("leftover_writes", exp_wr.size(), 0);
        check("leftover_b", exp_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
